// File: rtl/mdu.sv
// mdu: iterative 32x32 shift-add multiply / restoring divide into HI/LO; busy for 33 cycles, done pulses on the 34th.
// Start/HI/LO writes only accepted in IDLE (caller stalls on busy); MDU_DIV_EN compiles in the divide datapath.
module mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  hi_we,
  input  logic                  lo_we,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state, state_nxt;
  logic [5:0]      cnt;
  logic            is_div;
  logic            neg_res;
  logic [W-1:0]    mcand;
  logic [2*W-1:0]  acc;

  logic            sign_a, sign_b;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  prod;

  // Only signed ops (op[0] == 0) take magnitudes; |0x80000000| wraps to itself and is used unsigned.
  assign sign_a = A[W-1] & ~op[0];
  assign sign_b = B[W-1] & ~op[0];
  assign a_mag  = sign_a ? ({W{1'b0}} - A) : A;
  assign b_mag  = sign_b ? ({W{1'b0}} - B) : B;

  assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? mcand : {W{1'b0}})};
  assign prod    = neg_res ? ({(2*W){1'b0}} - acc) : acc;

`ifdef MDU_DIV_EN
  logic            neg_rem;
  logic            b_zero;
  logic [W:0]      rem;
  logic [W+1:0]    rem_sh;
  logic [W+1:0]    trial;
  logic [W-1:0]    quot, remd;

  assign rem_sh = {rem, acc[W-1]};
  assign trial  = rem_sh - {2'b00, mcand};
  // Divide by zero falls out naturally: all-ones quotient, remainder = |A| re-signed to A.
  assign quot   = (neg_res && !b_zero) ? ({W{1'b0}} - acc[W-1:0]) : acc[W-1:0];
  assign remd   = neg_rem ? ({W{1'b0}} - rem[W-1:0]) : rem[W-1:0];
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MDU_DIV_EN
          state_nxt = CALC;
`else
          state_nxt = op[1] ? FIX : CALC;
`endif
        end
      end
      CALC:    if (cnt == 6'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= 6'd0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      mcand   <= {W{1'b0}};
      acc     <= {(2*W){1'b0}};
      done    <= 1'b0;
      HI      <= {W{1'b0}};
      LO      <= {W{1'b0}};
`ifdef MDU_DIV_EN
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      rem     <= {(W+1){1'b0}};
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op[1];
            neg_res <= sign_a ^ sign_b;
            cnt     <= 6'd0;
            if (op[1]) begin
              acc   <= {{W{1'b0}}, a_mag};
              mcand <= b_mag;
`ifdef MDU_DIV_EN
              rem     <= {(W+1){1'b0}};
              neg_rem <= sign_a;
              b_zero  <= (B == {W{1'b0}});
`endif
            end else begin
              acc   <= {{W{1'b0}}, b_mag};
              mcand <= a_mag;
            end
          end else begin
            if (hi_we) HI <= A;
            if (lo_we) LO <= A;
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
`ifdef MDU_DIV_EN
          if (is_div) begin
            if (trial[W+1]) begin
              rem <= rem_sh[W:0];
              acc <= {acc[2*W-1:W], acc[W-2:0], 1'b0};
            end else begin
              rem <= trial[W:0];
              acc <= {acc[2*W-1:W], acc[W-2:0], 1'b1};
            end
          end else begin
            acc <= {mul_sum, acc[W-1:1]};
          end
`else
          acc <= {mul_sum, acc[W-1:1]};
`endif
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            HI <= prod[2*W-1:W];
            LO <= prod[W-1:0];
          end
`ifdef MDU_DIV_EN
          else begin
            HI <= remd;
            LO <= quot;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO and done edge; a negedge monitor checks every done pulse.
module tb_mdu;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] HI, LO;

  mdu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          edge_no;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  int          edge_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_hi, cur_lo;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at edge %0d expected none", edge_cnt);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("op%0d_done_edge", e.id), edge_cnt, e.edge_no);
        chk($sformatf("op%0d_hi", e.id), HI, e.hi);
        chk($sformatf("op%0d_lo", e.id), LO, e.lo);
      end
    end
  end

  // Entered and left at a negedge, so consecutive calls launch in the previous op's done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input int poke, input logic we, input int id);
    int n;
    start = 1'b1; op = o; A = a; B = b; hi_we = we;
    sb_q.push_back('{hi: eh, lo: el, edge_no: edge_cnt + 1 + lat, id: id});
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == poke) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; op = 2'b11; A = 32'hDEADBEEF; B = 32'h0;
      end else if (poke != 0 && n == poke + 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk($sformatf("op%0d_hi_hold", id), HI, cur_hi);
        chk($sformatf("op%0d_lo_hold", id), LO, cur_lo);
      end
      @(negedge clk);
    end
    chk($sformatf("op%0d_busy_cycles", id), n, lat);
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; A = 32'h0; B = 32'h0;
    cur_hi = 32'h0; cur_lo = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Multiplies, back-to-back.
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 0, 1'b0, 1);
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 0, 1'b0, 2);
    run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 0, 1'b0, 3);
    run_op(2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 33, 0, 1'b0, 4);
    // start wins over hi_we in the same cycle: HI must be the product high word, not A.
    run_op(2'b01, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 33, 0, 1'b1, 5);
    // start/hi_we/lo_we poked mid-CALC are ignored; HI/LO hold until the single done.
    run_op(2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33, 10, 1'b0, 6);

    // Divides: full results with the divider, otherwise one-cycle no-ops.
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, DIV_EN ? 32'hFFFFFFFF : cur_hi,
           DIV_EN ? 32'hFFFFFFFD : cur_lo, DIV_EN ? 33 : 1, 0, 1'b0, 7);
    run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, DIV_EN ? 32'h00000001 : cur_hi,
           DIV_EN ? 32'hFFFFFFFD : cur_lo, DIV_EN ? 33 : 1, 0, 1'b0, 8);
    run_op(2'b11, 32'h00000007, 32'h00000000, DIV_EN ? 32'h00000007 : cur_hi,
           DIV_EN ? 32'hFFFFFFFF : cur_lo, DIV_EN ? 33 : 1, 0, 1'b0, 9);
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000000, DIV_EN ? 32'hFFFFFFF9 : cur_hi,
           DIV_EN ? 32'hFFFFFFFF : cur_lo, DIV_EN ? 33 : 1, 0, 1'b0, 10);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32'h00000000 : cur_hi,
           DIV_EN ? 32'h80000000 : cur_lo, DIV_EN ? 33 : 1, 0, 1'b0, 11);
    run_op(2'b11, 32'hFFFFFFFF, 32'h00000010, DIV_EN ? 32'h0000000F : cur_hi,
           DIV_EN ? 32'h0FFFFFFF : cur_lo, DIV_EN ? 33 : 1, 0, 1'b0, 12);
    run_op(2'b11, 32'h00000007, 32'h00000002, DIV_EN ? 32'h00000001 : cur_hi,
           DIV_EN ? 32'h00000003 : cur_lo, DIV_EN ? 33 : 1, 0, 1'b0, 13);

    // Direct HI/LO writes in IDLE: visible next cycle, no busy, no done.
    @(negedge clk);
    lo_we = 1'b1; A = 32'h12345678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("lo_we_lo", LO, 32'h12345678);
    chk("lo_we_busy", busy, 0);
    chk("lo_we_done", done, 0);
    hi_we = 1'b1; A = 32'hCAFEF00D;
    @(negedge clk);
    hi_we = 1'b0;
    chk("hi_we_hi", HI, 32'hCAFEF00D);
    chk("hi_we_lo_kept", LO, 32'h12345678);

    // Reset 10 cycles into an op: immediate abort, registers cleared, no done afterwards.
    start = 1'b1; op = 2'b01; A = 32'h00001234; B = 32'h00005678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    resetn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    cur_hi = 32'h0;
    cur_lo = 32'h0;
    repeat (40) @(negedge clk);

    // Post-reset operation still works.
    run_op(2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 33, 0, 1'b0, 14);
    repeat (5) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

- Iterative multiply/divide unit in the execute stage, beside the ALU.
- Driven from the same A/B operand bus; implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers.
- Provides direct HI/LO writes for MTHI/MTLO.
- A start/busy/done handshake lets the pipeline controller stall dependent MFHI/MFLO reads while an operation is in flight.

## Interface

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; the only supported value is 32.

Ports:
- clk  input  1  sole clock, rising-edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  launch an operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  DATA_WIDTH  multiplicand/dividend; also the MTHI/MTLO write data.
- B  input  DATA_WIDTH  multiplier/divisor.
- hi_we  input  1  write HI <= A; honoured only in IDLE.
- lo_we  input  1  write LO <= A; honoured only in IDLE.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: HI/LO hold the new result.
- HI  output  DATA_WIDTH  HI register (product high word / remainder).
- LO  output  DATA_WIDTH  LO register (product low word / quotient).

## Operation

States are IDLE, CALC and FIX.

**IDLE**
- On start: latch op and the sign flags.
- Load the magnitudes |A| and |B|; for MULTU/DIVU use the raw values.
- Clear the 6-bit counter and go to CALC.
- start takes priority over hi_we/lo_we in the same cycle; the writes are dropped.

**CALC**
- Runs exactly 32 iterations, one per cycle, then goes to FIX.
- Multiply: radix-2 shift-add into a 64-bit accumulator.
- Divide: restoring divide; 33-bit partial remainder, 32-bit quotient shifted in from the LSB.

**FIX**
- Applies the sign correction, writes HI/LO, asserts done for one cycle and returns to IDLE.
- Signed product: negated if A[31]^B[31].
- Signed quotient: negated if A[31]^B[31] and B != 0.
- Signed remainder: takes the sign of A.

**Arithmetic rules**
- |0x80000000| = 0x80000000, treated as unsigned.
- Divide by zero, any signedness: LO = 0xFFFFFFFF, HI = A; full latency still applies.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.

**Inputs outside IDLE**
- start, hi_we and lo_we are ignored in CALC and FIX.
- The pipeline stalls issue while busy.
- op, A and B are don't-care after the launch cycle.

## Timing

- Reset: state IDLE; HI = 0, LO = 0, busy = 0, done = 0, counter = 0.
- resetn low mid-operation aborts immediately: no done, HI/LO cleared.
- Latency (launch is the edge that samples start=1 in IDLE, edge 0):
  - busy is high after edges 0 through 32 (33 cycles).
  - Edge 33 writes HI/LO, drops busy and raises done for one cycle.
- A new start may be accepted in the done cycle, i.e. back-to-back operations every 34 cycles.
- hi_we/lo_we in IDLE: HI/LO update on the next edge; no done pulse, busy stays low.
- HI/LO are registers and hold their value throughout CALC.

## Configuration

- MDU_DIV_EN defined:
  - Divide datapath (33-bit remainder, quotient logic) is compiled in.
  - DIV/DIVU behave as above.
- MDU_DIV_EN undefined:
  - Divide logic is omitted.
  - A DIV/DIVU start completes after edge 1 with a done pulse (busy high for one cycle) and HI/LO unchanged.
  - Multiply behaviour and timing are identical.

## Test plan

- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF: busy 33 cycles, then done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV A=0xFFFFFFF9 (-7), B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0: LO=0xFFFFFFFF, HI=7.
- DIV A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- Handshake and reset, in one run:
  - lo_we with A=0x12345678 in IDLE gives LO=0x12345678 next cycle.
  - start pulsed again mid-CALC is ignored; still exactly one done at edge 33.
  - resetn low at cycle 10 of a new op gives busy=0, HI=LO=0, and no done.
  - Without MDU_DIV_EN, DIVU 7/2 gives done after edge 1 with HI/LO unchanged.
